// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised VGA raster timing generator with pixel-tick divider
//            and a tick-aligned output delay pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int HD       = 640,
  parameter int HF       = 16,
  parameter int HR       = 96,
  parameter int HB       = 48,
  parameter int VD       = 480,
  parameter int VF       = 10,
  parameter int VR       = 2,
  parameter int VB       = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int PIPE_DLY = 0,
  parameter int CW       = 10
) (
  input  logic          clk_100MHz,
  input  logic          reset,
  input  logic          en,
  output logic          p_tick,
  output logic          video_on,
  output logic          hsync,
  output logic          vsync,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int HTOT = HD + HF + HR + HB;
  localparam int VTOT = VD + VF + VR + VB;
  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   H_LAST   = CW'(HTOT - 1);
  localparam logic [CW-1:0]   V_LAST   = CW'(VTOT - 1);
  localparam logic [CW-1:0]   H_DISP   = CW'(HD);
  localparam logic [CW-1:0]   V_DISP   = CW'(VD);
  localparam logic [CW-1:0]   HS_BEG   = CW'(HD + HF);
  localparam logic [CW-1:0]   HS_END   = CW'(HD + HF + HR - 1);
  localparam logic [CW-1:0]   VS_BEG   = CW'(VD + VF);
  localparam logic [CW-1:0]   VS_END   = CW'(VD + VF + VR - 1);
  localparam logic            HPOL     = 1'(H_POL);
  localparam logic            VPOL     = 1'(V_POL);

  if (CLK_DIV < 1 || PIPE_DLY < 0 || PIPE_DLY > 4 ||
      HD < 1 || HF < 1 || HR < 1 || HB < 1 ||
      VD < 1 || VF < 1 || VR < 1 || VB < 1 ||
      CW < 1 || CW > 30 || (2 ** CW) <= HTOT || (2 ** CW) <= VTOT) begin : g_param_err
    $fatal(1, "vga_timing_gen: illegal parameter set");
  end

  typedef struct packed {
    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic          vis;
    logic          hs;
    logic          vs;
    logic          ls;
    logic          fs;
  } stage_t;

  logic [DIVW-1:0] div_q, div_d;
  logic [CW-1:0]   h_q, h_d;
  logic [CW-1:0]   v_q, v_d;
  logic            tick;
  stage_t          raw;
  stage_t          last;

  assign tick = en && (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    if (en) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  always_comb begin
    raw     = '0;
    raw.h   = h_q;
    raw.v   = v_q;
    raw.vis = (h_q < H_DISP) && (v_q < V_DISP);
    raw.hs  = (h_q >= HS_BEG) && (h_q <= HS_END);
    raw.vs  = (v_q >= VS_BEG) && (v_q <= VS_END);
    raw.ls  = (h_q == '0);
    raw.fs  = (h_q == '0) && (v_q == '0);
  end

  // Stages advance only on the pixel tick so every field stays tick-aligned.
  if (PIPE_DLY == 0) begin : g_direct
    assign last = raw;
  end else begin : g_pipe
    stage_t pipe_q [PIPE_DLY];

    always_ff @(posedge clk_100MHz) begin
      if (reset) begin
        for (int i = 0; i < PIPE_DLY; i++) begin
          pipe_q[i] <= '0;
        end
      end else if (tick) begin
        pipe_q[0] <= raw;
        for (int i = 1; i < PIPE_DLY; i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign last = pipe_q[PIPE_DLY-1];
  end

  assign p_tick      = tick;
  assign x           = last.h;
  assign y           = last.v;
  assign video_on    = last.vis;
  assign hsync       = ~(last.hs ^ HPOL);
  assign vsync       = ~(last.vs ^ VPOL);
  assign line_start  = last.ls & tick;
  assign frame_start = last.fs & tick;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module   : tb_vga_timing_gen
// Purpose  : Directed self-checking bench for vga_timing_gen (four configs).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

  logic clk;
  logic reset;
  logic en;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  bit mon_on  = 0;

  // default 640x480 instance
  logic       d_pt, d_vis, d_hs, d_vs, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  // medium config, no delay and 2-tick delay
  logic       m_pt, m_vis, m_hs, m_vs, m_ls, m_fs;
  logic [9:0] m_x, m_y;
  logic       q_pt, q_vis, q_hs, q_vs, q_ls, q_fs;
  logic [9:0] q_x, q_y;
  // small active-high config
  logic       s_pt, s_vis, s_hs, s_vs, s_ls, s_fs;
  logic [3:0] s_x, s_y;

  vga_timing_gen #(.PIPE_DLY(0)) u_def (
    .clk_100MHz(clk), .reset(reset), .en(en), .p_tick(d_pt), .video_on(d_vis),
    .hsync(d_hs), .vsync(d_vs), .x(d_x), .y(d_y), .line_start(d_ls), .frame_start(d_fs)
  );

  vga_timing_gen #(.CLK_DIV(2), .HD(16), .HF(2), .HR(3), .HB(3),
                   .VD(10), .VF(2), .VR(2), .VB(3), .PIPE_DLY(0)) u_med (
    .clk_100MHz(clk), .reset(reset), .en(en), .p_tick(m_pt), .video_on(m_vis),
    .hsync(m_hs), .vsync(m_vs), .x(m_x), .y(m_y), .line_start(m_ls), .frame_start(m_fs)
  );

  vga_timing_gen #(.CLK_DIV(2), .HD(16), .HF(2), .HR(3), .HB(3),
                   .VD(10), .VF(2), .VR(2), .VB(3), .PIPE_DLY(2)) u_mdly (
    .clk_100MHz(clk), .reset(reset), .en(en), .p_tick(q_pt), .video_on(q_vis),
    .hsync(q_hs), .vsync(q_vs), .x(q_x), .y(q_y), .line_start(q_ls), .frame_start(q_fs)
  );

  vga_timing_gen #(.CLK_DIV(1), .HD(8), .HF(2), .HR(3), .HB(1),
                   .VD(4), .VF(1), .VR(1), .VB(1), .H_POL(1), .V_POL(1), .CW(4)) u_small (
    .clk_100MHz(clk), .reset(reset), .en(en), .p_tick(s_pt), .video_on(s_vis),
    .hsync(s_hs), .vsync(s_vs), .x(s_x), .y(s_y), .line_start(s_ls), .frame_start(s_fs)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns the number of falling edges waited until the default instance ticks.
  task automatic wait_dtick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!d_pt && n < 64);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Medium config: per-frame totals (HTOT=24, VTOT=17, CLK_DIV=2) and delay alignment.
  int m_frames = 0, m_ls_cnt = 0, m_vis_cnt = 0, m_hs_cnt = 0, m_vs_cnt = 0, m_err = 0;
  int m_fs_cyc = 0, dly_n = 0;
  bit m_have = 0;
  logic [22:0] h0, h1, cur, obs;
  localparam logic [22:0] BLANK = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1};

  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (m_pt) begin
          if (m_fs) begin
            if (m_have) begin
              check("m_fs_gap", cyc - m_fs_cyc, 816);
              check("m_ls_cnt", m_ls_cnt, 17);
              check("m_vis_cnt", m_vis_cnt, 160);
              check("m_hs_cnt", m_hs_cnt, 51);
              check("m_vs_cnt", m_vs_cnt, 48);
              check("m_pos_err", m_err, 0);
              m_frames++;
            end
            m_have = 1; m_fs_cyc = cyc;
            m_ls_cnt = 0; m_vis_cnt = 0; m_hs_cnt = 0; m_vs_cnt = 0; m_err = 0;
          end
          if (m_ls) m_ls_cnt++;
          if (m_vis) m_vis_cnt++;
          if (!m_hs) begin
            m_hs_cnt++;
            if (m_x < 18 || m_x > 20) m_err++;
          end
          if (!m_vs) begin
            m_vs_cnt++;
            if (m_y < 12 || m_y > 13) m_err++;
          end
          if (m_ls != (m_x == 0)) m_err++;
          cur = {m_x, m_y, m_vis, m_hs, m_vs};
          obs = {q_x, q_y, q_vis, q_hs, q_vs};
          check("dly_align", obs, (dly_n < 2) ? BLANK : h1);
          h1 = h0; h0 = cur; dly_n++;
        end else if (m_ls || m_fs) begin
          m_err++;
        end
      end
    end
  end

  // Small config: HTOT=14, VTOT=7, one tick per clk, active-high syncs.
  int s_frames = 0, s_hs_cnt = 0, s_vs_cnt = 0, s_ls_cnt = 0, s_err = 0, s_fs_cyc = 0;
  bit s_have = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_on && s_pt) begin
        if (s_fs) begin
          if (s_have) begin
            check("s_fs_gap", cyc - s_fs_cyc, 98);
            check("s_hs_cnt", s_hs_cnt, 21);
            check("s_vs_cnt", s_vs_cnt, 14);
            check("s_ls_cnt", s_ls_cnt, 7);
            check("s_pos_err", s_err, 0);
            s_frames++;
          end
          s_have = 1; s_fs_cyc = cyc;
          s_hs_cnt = 0; s_vs_cnt = 0; s_ls_cnt = 0; s_err = 0;
        end
        if (s_hs) begin
          s_hs_cnt++;
          if (s_x < 10 || s_x > 12) s_err++;
        end
        if (s_vs) begin
          s_vs_cnt++;
          if (s_y != 5) s_err++;
        end
        if (s_ls) s_ls_cnt++;
        if (s_x > 13 || s_y > 6) s_err++;
      end
    end
  end

  initial begin
    int n, t_line, per_err, seq_err, hs_lo, hs_first, hs_last, vis_cnt, vs_err, frz_err;
    logic [3:0] pt_seq;

    reset = 1'b1;
    en    = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_ptick", d_pt, 0);
    check("rst_x", d_x, 0);
    check("rst_y", d_y, 0);
    check("rst_hsync", d_hs, 1);
    check("rst_vsync", d_vs, 1);
    check("rst_lstart", d_ls, 0);
    check("rst_fstart", d_fs, 0);
    check("rst_dly_vis", q_vis, 0);
    check("rst_dly_hsync", q_hs, 1);

    reset  = 1'b0;
    mon_on = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      pt_seq[k] = d_pt;
    end
    check("ptick_phase", pt_seq, 4'b1000);
    check("first_x", d_x, 0);
    check("first_y", d_y, 0);
    check("first_lstart", d_ls, 1);
    check("first_fstart", d_fs, 1);
    t_line = cyc;

    per_err = 0; seq_err = 0; hs_lo = 0; hs_first = -1; hs_last = -1; vis_cnt = 0; vs_err = 0;
    for (int t = 0; t < 800; t++) begin
      if (t > 0) begin
        wait_dtick(n);
        if (n != 4) per_err++;
      end
      if (d_x != 10'(t) || d_y != 0) seq_err++;
      if (!d_hs) begin
        hs_lo++;
        if (hs_first < 0) hs_first = t;
        hs_last = t;
      end
      if (d_vis) vis_cnt++;
      if (!d_vs) vs_err++;
    end
    check("tick_period", per_err, 0);
    check("x_sequence", seq_err, 0);
    check("hs_low_cnt", hs_lo, 96);
    check("hs_first_x", hs_first, 656);
    check("hs_last_x", hs_last, 751);
    check("line_vis_cnt", vis_cnt, 640);
    check("line0_vsync", vs_err, 0);

    wait_dtick(n);
    check("wrap_gap", n, 4);
    check("wrap_x", d_x, 0);
    check("wrap_y", d_y, 1);
    check("wrap_lstart", d_ls, 1);
    check("wrap_fstart", d_fs, 0);
    check("line_clks", cyc - t_line, 3200);
    mon_on = 1'b0;
    check("med_frames_seen", m_frames >= 3, 1);
    check("small_frames_seen", s_frames >= 10, 1);
    check("dly_ticks_seen", dly_n >= 100, 1);

    // Freeze for 37 clks at x=100 on line 1.
    t_line = cyc;
    for (int g = 0; g < 200 && d_x != 100; g++) wait_dtick(n);
    check("reach_x100", d_x, 100);
    en = 1'b0;
    frz_err = 0;
    repeat (37) begin
      @(negedge clk);
      if (d_pt || d_x != 100 || d_y != 1 || d_ls || d_fs || !d_vis) frz_err++;
    end
    check("frozen", frz_err, 0);
    en = 1'b1;
    #1;
    check("resume_ptick", d_pt, 1);
    check("resume_x", d_x, 100);
    wait_dtick(n);
    check("resume_phase", n, 4);
    check("resume_next_x", d_x, 101);
    for (int g = 0; g < 1000 && d_x != 0; g++) wait_dtick(n);
    check("ext_line_y", d_y, 2);
    check("ext_line_clks", cyc - t_line, 3237);

    // One-clk reset mid-line at x=300.
    for (int g = 0; g < 400 && d_x != 300; g++) wait_dtick(n);
    check("reach_x300", d_x, 300);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_ptick", d_pt, 0);
    check("mid_rst_x", d_x, 0);
    check("mid_rst_y", d_y, 0);
    check("mid_rst_hsync", d_hs, 1);
    check("mid_rst_strobe", {d_ls, d_fs}, 0);
    check("mid_rst_dly_vis", q_vis, 0);
    wait_dtick(n);
    check("restart_gap", n, 3);
    check("restart_x", d_x, 0);
    check("restart_fstart", d_fs, 1);
    wait_dtick(n);
    check("restart_next_x", d_x, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
